// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encodings for the alarm input conditioner and the downstream alarm FSM.
//   Qualifier states: IDLE, WINDOW, TRIPPED.
//   Alarm FSM states: ALM_DISARMED, ALM_ARMED, ALM_PENDING, ALM_ALARM.
package alarm_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WINDOW  = 2'b01,
    TRIPPED = 2'b10
  } qual_state_t;
  localparam logic [1:0] ALM_DISARMED = 2'b00;
  localparam logic [1:0] ALM_ARMED    = 2'b01;
  localparam logic [1:0] ALM_PENDING  = 2'b10;
  localparam logic [1:0] ALM_ALARM    = 2'b11;
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: two-flop synchroniser followed by a consecutive-cycle debouncer.
//   clk, rst_n : clock, async active-low reset
//   i_ena      : when low the counter and stable value hold (synchroniser keeps running)
//   i_raw      : asynchronous raw input
//   o_stable   : debounced level
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ena,
  input  logic i_raw,
  output logic o_stable
);
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  logic [1:0] r_sync;
  logic [7:0] r_cnt;
  logic       r_stable;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (i_ena) begin
        if (r_sync[1] == r_stable) r_cnt <= '0;
        else if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync[1];
          r_cnt    <= '0;
        end else r_cnt <= r_cnt + 8'd1;
      end
    end
  end
  assign o_stable = r_stable;
endmodule

// File: rtl/alarm_input_conditioner.sv
// alarm_input_conditioner: debounces arm/sensor/confirm inputs and qualifies sensor hits into a sticky trip.
//   clk, rst_n     : clock, async active-low reset
//   ena            : clock enable for debounce, qualifier and outputs
//   arm_raw, sensor_raw, confirm_raw : asynchronous raw board inputs
//   clear_i        : returns the qualifier to IDLE and drops trip_o
//   arm_o          : debounced arm level
//   trip_o         : sticky qualified trip
//   confirm_o      : debounced confirm gated by trip_o, registered
//   hit_count      : hits counted in the current window
//   window_active  : qualifier is in WINDOW
module alarm_input_conditioner
  import alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WINDOW_CYCLES   = 16,
  parameter int TRIP_HITS       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       arm_raw,
  input  logic       sensor_raw,
  input  logic       confirm_raw,
  input  logic       clear_i,
  output logic       arm_o,
  output logic       trip_o,
  output logic       confirm_o,
  output logic [3:0] hit_count,
  output logic       window_active
);
  logic        w_arm, w_sensor, w_confirm, w_hit;
  logic [3:0]  w_count_inc, w_count_nx;
  logic [15:0] w_timer_nx;
  qual_state_t w_state_nx, r_state;
  logic [15:0] r_timer;
  logic [3:0]  r_hit_count;
  logic        r_sensor_prev, r_confirm;
  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arm (
    .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_raw(arm_raw), .o_stable(w_arm)
  );
  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sensor (
    .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_raw(sensor_raw), .o_stable(w_sensor)
  );
  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
    .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_raw(confirm_raw), .o_stable(w_confirm)
  );
  // The edge register holds with ena, so a pending hit survives an ena=0 gap.
  assign w_hit       = w_sensor & ~r_sensor_prev;
  assign w_count_inc = (r_hit_count == 4'hF) ? 4'hF : r_hit_count + 4'd1;
  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_count_nx = r_hit_count;
    if (clear_i) begin
      w_state_nx = IDLE;
      w_timer_nx = '0;
      w_count_nx = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            if (TRIP_HITS == 1) w_state_nx = TRIPPED;
            else begin
              w_state_nx = WINDOW;
              w_count_nx = 4'd1;
              w_timer_nx = '0;
            end
          end
        end
        WINDOW: begin
          w_timer_nx = r_timer + 16'd1;
          if (w_hit) w_count_nx = w_count_inc;
          // Trip wins over expiry when the last window cycle carries a hit.
          if (w_hit && w_count_inc == 4'(TRIP_HITS)) w_state_nx = TRIPPED;
          else if (r_timer == 16'(WINDOW_CYCLES - 1)) begin
            w_state_nx = IDLE;
            w_count_nx = '0;
          end
        end
        TRIPPED: ;
        default: w_state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_hit_count   <= '0;
      r_sensor_prev <= 1'b0;
      r_confirm     <= 1'b0;
    end else if (ena) begin
      r_state       <= w_state_nx;
      r_timer       <= w_timer_nx;
      r_hit_count   <= w_count_nx;
      r_sensor_prev <= w_sensor;
      r_confirm     <= w_confirm & trip_o;
    end
  end
  assign arm_o         = w_arm;
  assign trip_o        = (r_state == TRIPPED);
  assign window_active = (r_state == WINDOW);
  assign confirm_o     = r_confirm;
  assign hit_count     = r_hit_count;
endmodule

// File: tb/tb_alarm_input_conditioner.sv
// tb_alarm_input_conditioner: directed and random stimulus checked against a behavioural model.
module tb_alarm_input_conditioner;
  localparam int D = 4;
  localparam int W = 16;
  localparam int T = 2;
  logic       clk = 1'b0;
  logic       rst_n, ena, arm_raw, sensor_raw, confirm_raw, clear_i;
  logic       arm_o, trip_o, confirm_o, window_active;
  logic [3:0] hit_count;
  int n_total = 0;
  int n_bad   = 0;
  always #5 clk = ~clk;
  alarm_input_conditioner #(
    .DEBOUNCE_CYCLES(D), .WINDOW_CYCLES(W), .TRIP_HITS(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .arm_raw(arm_raw), .sensor_raw(sensor_raw),
    .confirm_raw(confirm_raw), .clear_i(clear_i), .arm_o(arm_o), .trip_o(trip_o),
    .confirm_o(confirm_o), .hit_count(hit_count), .window_active(window_active)
  );
  // Behavioural model: raw delayed two samples, a level is accepted after D
  // consecutive disagreeing enabled cycles; hits are counted against a window
  // measured in enabled ticks since the window opened.
  bit m_s1[3], m_s2[3], m_stab[3];
  int m_run[3];
  bit m_prev, m_win, m_trip, m_conf;
  int m_hits, m_t, m_t0;
  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_stab[c] = 0; m_run[c] = 0;
    end
    m_prev = 0; m_win = 0; m_trip = 0; m_conf = 0;
    m_hits = 0; m_t = 0; m_t0 = 0;
  endtask
  task automatic model_step();
    bit raw[3];
    bit hit, old_trip, old_conf;
    raw[0] = arm_raw; raw[1] = sensor_raw; raw[2] = confirm_raw;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hit      = m_stab[1] && !m_prev;
    old_trip = m_trip;
    old_conf = m_stab[2];
    if (ena) begin
      if (clear_i) begin
        m_win = 0; m_trip = 0; m_hits = 0;
      end else if (!m_trip) begin
        if (!m_win) begin
          if (hit) begin
            if (T == 1) m_trip = 1;
            else begin
              m_win = 1; m_hits = 1; m_t0 = m_t + 1;
            end
          end
        end else begin
          if (hit) m_hits++;
          if (hit && m_hits == T) begin
            m_trip = 1; m_win = 0;
          end else if (m_t - m_t0 == W - 1) begin
            m_win = 0; m_hits = 0;
          end
        end
      end
      m_conf = old_conf && old_trip;
      m_prev = m_stab[1];
      for (int c = 0; c < 3; c++) begin
        if (m_s2[c] != m_stab[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_stab[c] = m_s2[c];
            m_run[c] = 0;
          end
        end else m_run[c] = 0;
      end
      m_t++;
    end
    for (int c = 0; c < 3; c++) begin
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask
  task automatic chk_model();
    chk("arm_o", 32'(arm_o), 32'(m_stab[0]));
    chk("trip_o", 32'(trip_o), 32'(m_trip));
    chk("confirm_o", 32'(confirm_o), 32'(m_conf));
    chk("hit_count", 32'(hit_count), 32'(m_hits));
    chk("window_active", 32'(window_active), 32'(m_win));
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, 32'({arm_o, trip_o, confirm_o, hit_count, window_active}), 32'd0);
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk_model();
  endtask
  task automatic pulse(input int hi, input int lo);
    sensor_raw = 1;
    repeat (hi) step();
    sensor_raw = 0;
    repeat (lo) step();
  endtask
  int run_len[3];
  initial begin
    rst_n = 0; ena = 1; arm_raw = 0; sensor_raw = 0; confirm_raw = 0; clear_i = 0;
    model_reset();
    repeat (3) step();
    chk_zero("reset_outputs");
    rst_n = 1;
    repeat (4) step();
    chk_zero("post_reset_idle");
    arm_raw = 1;
    repeat (5) step();
    chk("arm_rise_edge4", 32'(arm_o), 32'd0);
    step();
    chk("arm_rise_edge5", 32'(arm_o), 32'd1);
    arm_raw = 0; repeat (3) step(); arm_raw = 1; repeat (8) step();
    chk("arm_glitch_low", 32'(arm_o), 32'd1);
    arm_raw = 0;
    repeat (5) step();
    chk("arm_fall_edge4", 32'(arm_o), 32'd1);
    step();
    chk("arm_fall_edge5", 32'(arm_o), 32'd0);
    arm_raw = 1; repeat (3) step(); arm_raw = 0; repeat (8) step();
    chk("arm_glitch_high", 32'(arm_o), 32'd0);
    confirm_raw = 1;
    pulse(6, 6);
    chk("first_hit_count", 32'(hit_count), 32'd1);
    chk("first_hit_window", 32'(window_active), 32'd1);
    chk("confirm_gated", 32'(confirm_o), 32'd0);
    pulse(6, 6);
    chk("trip_in_window", 32'(trip_o), 32'd1);
    chk("window_drops", 32'(window_active), 32'd0);
    chk("confirm_after_trip", 32'(confirm_o), 32'd1);
    pulse(6, 6);
    chk("third_hit_ignored", 32'(hit_count), 32'd2);
    confirm_raw = 0;
    clear_i = 1; step(); clear_i = 0;
    chk("clear_drops_trip", 32'(trip_o), 32'd0);
    repeat (8) step();
    pulse(6, 14);
    pulse(6, 14);
    chk("expiry_no_trip", 32'(trip_o), 32'd0);
    chk("expiry_new_window", 32'(hit_count), 32'd1);
    repeat (20) step();
    chk("expiry_second_window", 32'(window_active), 32'd0);
    pulse(6, 10);
    pulse(6, 10);
    chk("hit_on_last_cycle", 32'(trip_o), 32'd1);
    clear_i = 1; step(); clear_i = 0;
    pulse(6, 11);
    pulse(6, 11);
    chk("hit_after_window", 32'(trip_o), 32'd0);
    repeat (20) step();
    pulse(6, 6);
    sensor_raw = 1;
    repeat (6) step();
    clear_i = 1; step(); clear_i = 0;
    chk("clear_vs_hit_count", 32'(hit_count), 32'd0);
    chk("clear_vs_hit_window", 32'(window_active), 32'd0);
    sensor_raw = 0;
    repeat (10) step();
    pulse(6, 4);
    ena = 0;
    repeat (10) step();
    chk("freeze_window", 32'(window_active), 32'd1);
    chk("freeze_count", 32'(hit_count), 32'd1);
    ena = 1;
    pulse(6, 6);
    chk("trip_after_freeze", 32'(trip_o), 32'd1);
    clear_i = 1; step(); clear_i = 0;
    for (int c = 0; c < 3; c++) run_len[c] = 1;
    for (int i = 0; i < 1500; i++) begin
      if (run_len[0] == 0) begin arm_raw = ~arm_raw; run_len[0] = $urandom_range(1, 12); end
      if (run_len[1] == 0) begin sensor_raw = ~sensor_raw; run_len[1] = $urandom_range(1, 12); end
      if (run_len[2] == 0) begin confirm_raw = ~confirm_raw; run_len[2] = $urandom_range(1, 12); end
      for (int c = 0; c < 3; c++) run_len[c]--;
      ena = ($urandom_range(0, 9) != 0);
      clear_i = ($urandom_range(0, 59) == 0);
      if (i == 700) begin
        #2 rst_n = 0;
        #1 model_reset();
        chk_zero("async_reset_mid_run");
        step(); step();
        chk_zero("held_in_reset");
        rst_n = 1;
      end
      step();
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
